// File: rtl/ring_mon_pkg.sv
// Shared types and helpers for the ring/Johnson code monitor.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ring_mon_pkg;

    typedef enum logic [1:0] {
        SYNC   = 2'd0,
        LOCKED = 2'd1,
        FAULT  = 2'd2
    } state_t;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_ILLEGAL = 2'b01;
    localparam logic [1:0] ERR_SKIP    = 2'b10;

    // A ring of N bits has N phases; a Johnson counter of N bits has 2N.
    function automatic int num_phases(input int n, input int johnson);
        return (johnson != 0) ? 2 * n : n;
    endfunction

endpackage

// File: rtl/ring_code_monitor_if.sv
// Bundle between the upstream counter/control side and the code monitor.
// Latency: n/a (wires only).
// Backpressure: none; the monitor observes every cycle unconditionally.
interface ring_code_monitor_if #(
    parameter int N  = 10,
    parameter int RW = 8
);
    localparam int IW = $clog2(2 * N);

    logic [N-1:0]  code_in;
    logic          clr_err_in;
    logic [IW-1:0] phase_out;
    logic          valid_out;
    logic          lock_out;
    logic          err_out;
    logic [1:0]    err_code_out;
    logic          wrap_out;
    logic [RW-1:0] rev_count_out;

    modport master (
        output code_in, clr_err_in,
        input  phase_out, valid_out, lock_out, err_out, err_code_out,
               wrap_out, rev_count_out
    );

    modport slave (
        input  code_in, clr_err_in,
        output phase_out, valid_out, lock_out, err_out, err_code_out,
               wrap_out, rev_count_out
    );

endinterface

// File: rtl/ring_code_decode.sv
// Combinational decode of a ring or Johnson code word into a phase index plus legality.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
module ring_code_decode #(
    parameter int  N       = 10,
    parameter int  JOHNSON = 0,
    localparam int IW      = $clog2(2 * N)
) (
    input  logic [N-1:0]  code,
    output logic [IW-1:0] idx,
    output logic          legal
);

    generate
        if (JOHNSON != 0) begin : g_johnson
            int           pc;
            int           jidx;
            logic [N-1:0] canon;

            // Index from popcount and MSB, then regenerate the canonical word to prove legality
            always_comb begin
                pc = 0;
                for (int b = 0; b < N; b++) begin
                    if (code[b]) pc = pc + 1;
                end
                jidx  = code[N-1] ? (2 * N - pc) : pc;
                canon = '0;
                for (int b = 0; b < N; b++) begin
                    canon[b] = (jidx < N) ? (b < jidx) : (b >= jidx - N);
                end
            end

            assign idx   = IW'(jidx);
            assign legal = (code == canon);
        end else begin : g_ring
            int pc;
            int pos;

            // One-hot check; index is the position of the single set bit
            always_comb begin
                pc  = 0;
                pos = 0;
                for (int b = 0; b < N; b++) begin
                    if (code[b]) begin
                        pc  = pc + 1;
                        pos = b;
                    end
                end
            end

            assign idx   = IW'(pos);
            assign legal = (pc == 1);
        end
    endgenerate

endmodule

// File: rtl/ring_code_monitor.sv
// In-line checker for the ring/Johnson counter: lock, sticky fault, wrap pulse, lap count.
// Latency: 1 cycle from code_in to every output.
// Backpressure: none; observes every cycle, never stalls the counter.
module ring_code_monitor
    import ring_mon_pkg::*;
#(
    parameter int N        = 10,
    parameter int JOHNSON  = 0,
    parameter int LOCK_CNT = 3,
    parameter int RW       = 8
) (
    input  logic               clk,
    input  logic               reset_al_in,
    ring_code_monitor_if.slave mon
);

    localparam int IW = $clog2(2 * N);
    localparam int P  = num_phases(N, JOHNSON);
    localparam int SW = $clog2(LOCK_CNT + 1);

    logic [IW-1:0] idx;
    logic          legal;
    logic [IW-1:0] prev_idx;
    logic [IW-1:0] nxt_idx;
    logic          at_last;
    logic          is_hold;
    logic          is_adv;

    state_t        state;
    logic [SW-1:0] streak;
    logic [1:0]    err_code;
    logic          wrap;
    logic [RW-1:0] rev;

    ring_code_decode #(
        .N       (N),
        .JOHNSON (JOHNSON)
    ) u_decode (
        .code  (mon.code_in),
        .idx   (idx),
        .legal (legal)
    );

    // Wrap is an explicit compare against the last phase, so P need not be a power of two
    assign at_last = (prev_idx == IW'(P - 1));
    assign nxt_idx = at_last ? '0 : prev_idx + IW'(1);
    assign is_hold = (idx == prev_idx);
    assign is_adv  = (idx == nxt_idx);

    // Lock FSM, step history and revolution bookkeeping
    always_ff @(posedge clk) begin
        if (!reset_al_in) begin
            state    <= SYNC;
            streak   <= '0;
            prev_idx <= '0;
            err_code <= ERR_NONE;
            wrap     <= 1'b0;
            rev      <= '0;
        end else begin
            wrap <= 1'b0;
            // An illegal word carries no trustworthy phase, so history only follows legal ones
            if (legal) prev_idx <= idx;
            case (state)
                SYNC: begin
                    if (legal && is_adv) begin
                        if (streak == SW'(LOCK_CNT - 1)) begin
                            state  <= LOCKED;
                            streak <= '0;
                        end else begin
                            streak <= streak + SW'(1);
                        end
                    end else if (!(legal && is_hold)) begin
                        streak <= '0;
                    end
                end
                LOCKED: begin
                    if (!legal) begin
                        state    <= FAULT;
                        err_code <= ERR_ILLEGAL;
                    end else if (!is_adv && !is_hold) begin
                        state    <= FAULT;
                        err_code <= ERR_SKIP;
                    end else if (is_adv && at_last) begin
                        wrap <= 1'b1;
                        if (rev != {RW{1'b1}}) rev <= rev + RW'(1);
                    end
                end
                FAULT: begin
                    if (mon.clr_err_in) begin
                        state    <= SYNC;
                        streak   <= '0;
                        err_code <= ERR_NONE;
                    end
                end
                default: begin
                    state <= SYNC;
                end
            endcase
        end
    end

    assign mon.phase_out     = prev_idx;
    assign mon.valid_out     = (state == LOCKED);
    assign mon.lock_out      = (state == LOCKED);
    assign mon.err_out       = (state == FAULT);
    assign mon.err_code_out  = err_code;
    assign mon.wrap_out      = wrap;
    assign mon.rev_count_out = rev;

endmodule
